// File: rtl/mod_frame_ctrl_pkg.sv
// Shared PHY definitions for the frame controller.
// Holds the state encoding, bits-per-symbol constants and the pad helper.
package mod_frame_ctrl_pkg;

  localparam int LEN_W_DEF = 11;
  localparam int BPS_QAM16 = 4;
  localparam int BPS_QPSK  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAD   = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // bps is a power of two, so (bps - len mod bps) mod bps is (-len) masked by bps-1.
  function automatic logic [2:0] calc_pad(input logic [1:0] len_lsb, input logic qam);
    logic [2:0] mask;
    mask = qam ? 3'(BPS_QAM16 - 1) : 3'(BPS_QPSK - 1);
    return (3'd0 - {1'b0, len_lsb}) & mask;
  endfunction

endpackage

// File: rtl/mod_frame_ctrl_if.sv
// One-bit Wishbone-style stream link; used both toward the bit source and toward the mapper.
// The master drives data/strobes, the slave answers with ack.
interface mod_frame_ctrl_if;
  logic dat;
  logic cyc;
  logic stb;
  logic we;
  logic ack;

  modport master (output dat, output cyc, output stb, output we, input ack);
  modport slave  (input dat, input cyc, input stb, input we, output ack);
endinterface

// File: rtl/mod_out_stage.sv
// One-entry output register: loaded bit shows with stb the next cycle and holds until acked.
// rdy_o tells the producer a load this cycle cannot overwrite an unaccepted bit.
module mod_out_stage (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  logic dat_i,
  input  logic ack_i,
  output logic rdy_o,
  output logic stb_o,
  output logic dat_o
);

  logic stb_q;
  logic dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q <= 1'b0;
      dat_q <= 1'b0;
    end else if (clr_i) begin
      stb_q <= 1'b0;
      dat_q <= 1'b0;
    end else if (load_i) begin
      stb_q <= 1'b1;
      dat_q <= dat_i;
    end else if (ack_i) begin
      stb_q <= 1'b0;
    end
  end

  assign rdy_o = ~stb_q | ack_i;
  assign stb_o = stb_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/mod_frame_ctrl.sv
// Frame controller: pulls frame_len bits from the source, pads with zeros to a whole symbol,
// and forwards them through a one-entry register to the mapper (1-cycle latency, stalls on ACK_I).
module mod_frame_ctrl
  import mod_frame_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             start,
  input  logic             mode_req,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  mod_frame_ctrl_if.slave  src,
  mod_frame_ctrl_if.master map,
  output logic             QAM,
  output logic             QPSK,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [2:0]       pad_q;
  logic [2:0]       pad_cnt_q;
  logic             qam_q;
  logic             cyc_q;
  logic             done_q;
  logic             err_q;

  logic stg_rdy;
  logic stg_stb;
  logic stg_dat;
  logic stg_load;
  logic stg_load_dat;
  logic stg_clr;
  logic src_ack;
  logic pad_inject;
  logic last_bit;
  logic last_pad;
  logic aborting;

  assign aborting   = abort & (state_q != ST_IDLE);
  assign src_ack    = src.cyc & src.stb & src.we & (state_q == ST_RUN) & stg_rdy;
  assign pad_inject = (state_q == ST_PAD) & stg_rdy;
  assign last_bit   = (cnt_q == len_q - LEN_W'(1));
  assign last_pad   = (pad_cnt_q == pad_q - 3'd1);

  // Abort drops whatever sits in the output register, even a bit accepted this cycle.
  assign stg_clr      = aborting;
  assign stg_load     = src_ack | pad_inject;
  assign stg_load_dat = (state_q == ST_RUN) ? src.dat : 1'b0;

  mod_out_stage u_out_stage (
    .clk_i  (CLK_I),
    .rst_ni (RST_I),
    .clr_i  (stg_clr),
    .load_i (stg_load),
    .dat_i  (stg_load_dat),
    .ack_i  (map.ack),
    .rdy_o  (stg_rdy),
    .stb_o  (stg_stb),
    .dat_o  (stg_dat)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      pad_q     <= '0;
      pad_cnt_q <= '0;
      qam_q     <= 1'b0;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (aborting) begin
        state_q   <= ST_IDLE;
        cyc_q     <= 1'b0;
        err_q     <= 1'b1;
        cnt_q     <= '0;
        pad_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              len_q     <= frame_len;
              cnt_q     <= '0;
              pad_cnt_q <= '0;
              state_q   <= ST_CFG;
            end
          end
          ST_CFG: begin
            qam_q <= mode_req;
            pad_q <= calc_pad(len_q[1:0], mode_req);
            if (len_q == '0) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cyc_q   <= 1'b1;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (src_ack) begin
              cnt_q <= cnt_q + LEN_W'(1);
              if (last_bit) state_q <= (pad_q != 3'd0) ? ST_PAD : ST_FLUSH;
            end
          end
          ST_PAD: begin
            if (pad_inject) begin
              pad_cnt_q <= pad_cnt_q + 3'd1;
              if (last_pad) state_q <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            // stg_rdy here means the register is empty after this edge.
            if (stg_rdy) begin
              cyc_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign src.ack = src_ack;
  assign map.dat = stg_dat;
  assign map.stb = stg_stb;
  assign map.we  = stg_stb;
  assign map.cyc = cyc_q;
  assign QAM     = qam_q;
  assign QPSK    = ~qam_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mod_frame_ctrl.sv
// Bench for mod_frame_ctrl: expected output stream = payload bits then zeros to a whole symbol.
module tb_mod_frame_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        start, mode_req, abort;
  logic [10:0] frame_len;
  logic        QAM, QPSK, busy, done, err;

  mod_frame_ctrl_if src_if();
  mod_frame_ctrl_if map_if();

  mod_frame_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .mode_req(mode_req),
    .frame_len(frame_len), .abort(abort), .src(src_if), .map(map_if),
    .QAM(QAM), .QPSK(QPSK), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0;
  int n_fail = 0;

  bit src_bits [0:63];
  bit exp_bits [0:63];
  int exp_len = 0;
  bit exp_qam = 0;
  int src_base = 0;
  int xfer_base = 0;

  int xfer_cnt = 0;
  int ack_count = 0;
  int cyc_hi = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit prev_stall = 0;
  bit prev_dat = 0;
  bit prev_abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Compare process: checks every sampled cycle against the stream model.
  always @(negedge CLK_I) begin
    int idx;
    if (RST_I) begin
      chk("we_eq_stb", map_if.we, map_if.stb);
      chk("mode_onehot", QAM ^ QPSK, 1);
      if (map_if.cyc) chk("mode_during_frame", QAM, exp_qam);
      if (map_if.stb) chk("stb_inside_cyc", map_if.cyc, 1);
      if (prev_stall && !prev_abort) begin
        chk("stall_hold_stb", map_if.stb, 1);
        chk("stall_hold_dat", map_if.dat, prev_dat);
      end
      if (map_if.stb && map_if.ack) begin
        idx = xfer_cnt - xfer_base;
        if (idx < exp_len) chk("xfer_dat", map_if.dat, exp_bits[idx]);
        else begin
          n_chk++;
          n_fail++;
          $display("FAIL xfer_extra: transfer %0d, expected only %0d", idx + 1, exp_len);
        end
        xfer_cnt++;
      end
      if (src_if.ack) ack_count++;
      if (map_if.cyc) cyc_hi++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      prev_stall = map_if.stb & ~map_if.ack;
      prev_dat   = map_if.dat;
      prev_abort = abort;
    end else begin
      prev_stall = 0;
    end
  end

  // Bit source: always valid, presents the next unaccepted bit after each edge.
  always @(posedge CLK_I) begin
    #1;
    src_if.dat = src_bits[(ack_count - src_base) & 63];
  end

  task automatic kick_frame(input bit qam, input int len);
    int bps;
    bps = qam ? 4 : 2;
    for (int i = 0; i < 64; i++) begin
      src_bits[i] = 1'($urandom);
      exp_bits[i] = 1'b0;
    end
    for (int i = 0; i < len; i++) exp_bits[i] = src_bits[i];
    exp_len = ((len + bps - 1) / bps) * bps;
    exp_qam = qam;
    @(posedge CLK_I); #1;
    src_base  = ack_count;
    xfer_base = xfer_cnt;
    mode_req  = qam;
    frame_len = 11'(len);
    start     = 1'b1;
    @(posedge CLK_I); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit qam, input int len, input int stall_after,
                           input int stall_n, input int restart_after, output int lat);
    int stall_left;
    bit restarted;
    kick_frame(qam, len);
    lat = -1;
    stall_left = stall_n;
    restarted = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge CLK_I); #1;
      if (done || err) begin
        lat = c;
        break;
      end
      if (stall_left > 0 && (ack_count - src_base) >= stall_after) begin
        map_if.ack = 1'b0;
        stall_left--;
      end else map_if.ack = 1'b1;
      if (restart_after >= 0 && !restarted && (ack_count - src_base) >= restart_after) begin
        start = 1'b1;
        frame_len = 11'd3;
        restarted = 1;
      end else start = 1'b0;
    end
    map_if.ack = 1'b1;
    start = 1'b0;
    if (lat < 0) fail_now("frame_end_wait");
    if (done) begin
      chk("cyc_low_at_done", map_if.cyc, 0);
      chk("busy_at_done", busy, 1);
    end
    @(posedge CLK_I); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_frame", busy, 0);
  endtask

  initial begin
    int lat, d0, e0, x0, a0, c0;
    bit found;
    RST_I = 1'b0;
    start = 1'b0; mode_req = 1'b0; abort = 1'b0; frame_len = '0;
    src_if.cyc = 1'b1; src_if.stb = 1'b1; src_if.we = 1'b1; src_if.dat = 1'b0;
    map_if.ack = 1'b1;

    #12;
    chk("rst_stb", map_if.stb, 0);
    chk("rst_cyc", map_if.cyc, 0);
    chk("rst_we", map_if.we, 0);
    chk("rst_dat", map_if.dat, 0);
    chk("rst_ack_o", src_if.ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_qam", QAM, 0);
    chk("rst_qpsk", QPSK, 1);
    @(negedge CLK_I); @(negedge CLK_I);
    RST_I = 1'b1;

    // QAM16, 8 bits: no pad, CFG + 8 + FLUSH edges to done.
    d0 = done_cnt; e0 = err_cnt; x0 = xfer_cnt; a0 = ack_count;
    run_frame(1, 8, 1000, 0, -1, lat);
    chk("q8_latency", lat, 10);
    chk("q8_xfers", xfer_cnt - x0, 8);
    chk("q8_acks", ack_count - a0, 8);
    chk("q8_done", done_cnt - d0, 1);
    chk("q8_err", err_cnt - e0, 0);
    chk("q8_qam_held", QAM, 1);

    // QPSK, 5 bits: one zero pad bit.
    d0 = done_cnt; e0 = err_cnt; x0 = xfer_cnt;
    run_frame(0, 5, 1000, 0, -1, lat);
    chk("p5_latency", lat, 8);
    chk("p5_xfers", xfer_cnt - x0, 6);
    chk("p5_done", done_cnt - d0, 1);
    chk("p5_err", err_cnt - e0, 0);
    chk("p5_qpsk_held", QPSK, 1);

    // QAM16, 10 bits with a 3-cycle mapper stall: 2 pad bits.
    d0 = done_cnt; x0 = xfer_cnt;
    run_frame(1, 10, 4, 3, -1, lat);
    chk("q10_xfers", xfer_cnt - x0, 12);
    chk("q10_done", done_cnt - d0, 1);
    chk("q10_qam_idle", QAM, 1);

    // Abort on the 4th accepted bit of a 16-bit frame.
    d0 = done_cnt; e0 = err_cnt; x0 = xfer_cnt;
    kick_frame(1, 16);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK_I); #2;
      if ((ack_count - src_base) == 3 && src_if.ack) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("abort_setup");
    abort = 1'b1;
    @(posedge CLK_I); #1;
    abort = 1'b0;
    chk("abort_cyc", map_if.cyc, 0);
    chk("abort_stb", map_if.stb, 0);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge CLK_I); #1;
    chk("abort_err_pulse", err, 0);
    repeat (3) @(posedge CLK_I);
    #1;
    chk("abort_acks", ack_count - src_base, 4);
    chk("abort_xfers", xfer_cnt - x0, 3);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_err_cnt", err_cnt - e0, 1);

    // Zero-length frame.
    d0 = done_cnt; e0 = err_cnt; c0 = cyc_hi;
    run_frame(1, 0, 1000, 0, -1, lat);
    chk("z_latency", lat, 1);
    chk("z_err", err_cnt - e0, 1);
    chk("z_no_done", done_cnt - d0, 0);
    chk("z_no_cyc", cyc_hi - c0, 0);

    // Start pulsed mid-frame is ignored.
    d0 = done_cnt; x0 = xfer_cnt;
    run_frame(0, 6, 1000, 0, 2, lat);
    chk("rs_latency", lat, 8);
    chk("rs_xfers", xfer_cnt - x0, 6);
    chk("rs_done", done_cnt - d0, 1);
    c0 = cyc_hi;
    repeat (4) begin
      @(posedge CLK_I); #1;
      chk("rs_idle_busy", busy, 0);
    end
    chk("rs_no_second_frame", cyc_hi - c0, 0);

    // Reset pulse while padding (QAM16, 9 bits -> 3 pad bits).
    kick_frame(1, 9);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK_I); #2;
      if ((ack_count - src_base) == 9) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("pad_reach");
    RST_I = 1'b0;
    #1;
    chk("prst_stb", map_if.stb, 0);
    chk("prst_cyc", map_if.cyc, 0);
    chk("prst_we", map_if.we, 0);
    chk("prst_dat", map_if.dat, 0);
    chk("prst_ack_o", src_if.ack, 0);
    chk("prst_busy", busy, 0);
    chk("prst_qam", QAM, 0);
    chk("prst_qpsk", QPSK, 1);
    @(posedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b1;
    x0 = xfer_cnt;
    repeat (6) begin
      @(posedge CLK_I); #1;
      chk("prst_idle_stb", map_if.stb, 0);
      chk("prst_idle_busy", busy, 0);
    end
    chk("prst_no_xfer", xfer_cnt - x0, 0);
    chk("prst_qpsk_hold", QPSK, 1);

    // Recovery frame after reset.
    d0 = done_cnt; x0 = xfer_cnt;
    run_frame(0, 4, 1000, 0, -1, lat);
    chk("rec_xfers", xfer_cnt - x0, 4);
    chk("rec_done", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
